// File: rtl/argo_chan_pkg.sv
// Shared definitions for the Argo channel endpoints (receive now, send later).
// Optional feature macro: ARGO_CHAN_CLOSE_EN (channel close / drain support).
package argo_chan_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    CLOSED = 2'd2
  } chan_state_t;

`ifdef ARGO_CHAN_CLOSE_EN
  localparam bit CLOSE_EN_DEFAULT = 1'b1;
`else
  localparam bit CLOSE_EN_DEFAULT = 1'b0;
`endif

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUF_DEPTH  = 2;
  localparam int MIN_BUF_DEPTH  = 2;
  localparam int MAX_BUF_DEPTH  = 4;

endpackage

// File: rtl/argo_chan_recv_if.sv
// Channel FIFO read port plus the thread-side blocking receive handshake.
// master = receive endpoint, slave = FIFO/thread environment.
interface argo_chan_recv_if
  import argo_chan_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  recv_req;
  logic                  recv_ack;
  logic [DATA_WIDTH-1:0] recv_data;
  logic                  recv_ok;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    input  recv_req,
    output recv_ack,
    output recv_data,
    output recv_ok
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    output recv_req,
    input  recv_ack,
    input  recv_data,
    input  recv_ok
  );
endinterface

// File: rtl/argo_prefetch_buf.sv
// Small circular register buffer holding words prefetched from the channel FIFO.
// Head entry is always visible on o_head; pop must only be asserted when o_occ != 0.
module argo_prefetch_buf
  import argo_chan_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [DATA_WIDTH-1:0]          i_push_data,
  input  logic                           i_pop,
  output logic [DATA_WIDTH-1:0]          o_head,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_occ
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Data storage; no reset needed since occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) r_occ <= OCC_MAX);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) i_pop |-> (r_occ != '0));
endmodule

// File: rtl/argo_chan_recv.sv
// Receive endpoint of a compiled Argo channel: prefetches from the channel FIFO
// and serves one blocking receive per cycle to the thread FSM.
// Optional feature macro: ARGO_CHAN_CLOSE_EN adds chan_closed and the DRAIN/CLOSED states.
module argo_chan_recv
  import argo_chan_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ARGO_CHAN_CLOSE_EN
  input  logic             chan_closed,
`endif
  argo_chan_recv_if.master bus
);
  localparam int OCC_W = $clog2(BUF_DEPTH+1);
  localparam logic [OCC_W:0] DEPTH_LIM = BUF_DEPTH[OCC_W:0];

  if (BUF_DEPTH < MIN_BUF_DEPTH || BUF_DEPTH > MAX_BUF_DEPTH) begin : g_bad_depth
    $error("argo_chan_recv: BUF_DEPTH must be within 2..4");
  end

  chan_state_t           r_state;
  chan_state_t           w_state_nxt;
  logic                  r_infl;
  logic                  w_rd_en;
  logic                  w_ack;
  logic                  w_ok;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] w_head;
  logic [OCC_W-1:0]      w_occ;
  logic [OCC_W:0]        w_need;

  argo_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_infl),
    .i_push_data (bus.fifo_rd_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  // State register and in-flight flag; reset drops any word still on its way from the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_infl  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_infl  <= w_rd_en;
    end
  end

  // Receive handshake and next-state logic; acks only from buffered data (no FIFO bypass).
  always_comb begin
    w_ack       = 1'b0;
    w_ok        = 1'b1;
    w_pop       = 1'b0;
    w_data      = '0;
    w_state_nxt = r_state;
    case (r_state)
      RUN, DRAIN: begin
        w_ack = bus.recv_req & (w_occ != '0) & ~rst;
        w_pop = w_ack;
        if (w_ack) w_data = w_head;
      end
      CLOSED: begin
        w_ack = bus.recv_req & ~rst;
        w_ok  = 1'b0;
      end
      default: ;
    endcase
`ifdef ARGO_CHAN_CLOSE_EN
    case (r_state)
      RUN:     if (chan_closed) w_state_nxt = DRAIN;
      DRAIN:   if (bus.fifo_empty && (w_occ == '0) && !r_infl) w_state_nxt = CLOSED;
      default: ;
    endcase
`endif
  end

  // Slots committed after this edge; the in-flight word already owns one.
  assign w_need  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_infl} - {{OCC_W{1'b0}}, w_pop};
  assign w_rd_en = ~rst & ~bus.fifo_empty & (w_need < DEPTH_LIM) & (r_state != CLOSED);

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.recv_ack   = w_ack;
  assign bus.recv_data  = w_data;
  assign bus.recv_ok    = w_ok;
endmodule

// File: tb/tb_argo_chan_recv.sv
// Directed bench for argo_chan_recv with a behavioural channel FIFO
// (synchronous read, registered empty). Build with ARGO_CHAN_CLOSE_EN to add the close scenario.
module tb_argo_chan_recv;
  localparam int BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rst = 1'b0;
  logic        recv_req = 1'b0;
`ifdef ARGO_CHAN_CLOSE_EN
  logic        chan_closed = 1'b0;
`endif

  logic [31:0] fmem [64];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          overread = 0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  argo_chan_recv_if #(.DATA_WIDTH(32)) bus ();
  assign bus.fifo_rd_data = fifo_rd_data;
  assign bus.fifo_empty   = fifo_empty;
  assign bus.recv_req     = recv_req;

  argo_chan_recv #(
    .DATA_WIDTH (32),
    .BUF_DEPTH  (BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ARGO_CHAN_CLOSE_EN
    .chan_closed (chan_closed),
`endif
    .bus         (bus)
  );

  // Channel FIFO model; its reset is separate so the reset test can hold it non-empty.
  always @(posedge clk) begin
    if (fifo_rst) begin
      rd_idx     <= wr_idx;
      fifo_empty <= 1'b1;
    end else if (bus.fifo_rd_en && (rd_idx != wr_idx)) begin
      fifo_rd_data <= fmem[rd_idx[5:0]];
      rd_idx       <= rd_idx + 1;
      fifo_empty   <= ((rd_idx + 1) == wr_idx);
    end else begin
      if (bus.fifo_rd_en) overread <= overread + 1;
      fifo_empty <= (rd_idx == wr_idx);
    end
  end

  task automatic push_word(input logic [31:0] v);
    fmem[wr_idx[5:0]] = v;
    wr_idx = wr_idx + 1;
  endtask

  task automatic test_reset();
    push_word(32'hDEADBEEF);
    rst = 1'b1;
    recv_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.fifo_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_rd_en cyc%0d got=%b exp=0", i, bus.fifo_rd_en);
      end
      n_cmp++;
      if (bus.recv_ack !== 1'b0) begin
        n_fail++; $display("FAIL reset_ack cyc%0d got=%b exp=0", i, bus.recv_ack);
      end
      n_cmp++;
      if (bus.recv_data !== 32'h0) begin
        n_fail++; $display("FAIL reset_data cyc%0d got=%h exp=0", i, bus.recv_data);
      end
    end
  endtask

  task automatic test_single();
    int rd_cnt = 0;
    int ack_cnt = 0;
    int first_ack = -1;
    logic [31:0] got = '0;
    logic got_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst = 1'b0;
        recv_req = 1'b1;
      end else if (ack_cnt != 0) begin
        recv_req = 1'b0;
      end
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.recv_ack) begin
        if (ack_cnt == 0) begin
          first_ack = i;
          got = bus.recv_data;
          got_ok = bus.recv_ok;
        end
        ack_cnt++;
      end
    end
    n_cmp++;
    if (rd_cnt !== 1) begin n_fail++; $display("FAIL single_rd_pulses got=%0d exp=1", rd_cnt); end
    n_cmp++;
    if (first_ack !== 2) begin n_fail++; $display("FAIL single_latency got=%0d exp=2", first_ack); end
    n_cmp++;
    if (ack_cnt !== 1) begin n_fail++; $display("FAIL single_acks got=%0d exp=1", ack_cnt); end
    n_cmp++;
    if (got !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got=%h exp=deadbeef", got); end
    n_cmp++;
    if (got_ok !== 1'b1) begin n_fail++; $display("FAIL single_ok got=%b exp=1", got_ok); end
    n_cmp++;
    if (bus.recv_data !== 32'h0) begin n_fail++; $display("FAIL single_idle_data got=%h exp=0", bus.recv_data); end
  endtask

  task automatic test_stream();
    int rd_cnt = 0;
    int ack_cnt = 0;
    int first_ack = -1;
    int last_ack = -1;
    logic [31:0] exp_v = 32'd1;
    recv_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 1; k <= 8; k++) push_word(32'(k));
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      recv_req = 1'b1;
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.recv_ack) begin
        if (first_ack < 0) first_ack = i;
        last_ack = i;
        ack_cnt++;
        n_cmp++;
        if (bus.recv_data !== exp_v) begin
          n_fail++; $display("FAIL stream_data got=%h exp=%h", bus.recv_data, exp_v);
        end
        exp_v = exp_v + 1;
      end
    end
    recv_req = 1'b0;
    n_cmp++;
    if (ack_cnt !== 8) begin n_fail++; $display("FAIL stream_acks got=%0d exp=8", ack_cnt); end
    n_cmp++;
    if ((last_ack - first_ack) !== 7) begin
      n_fail++; $display("FAIL stream_consecutive got_span=%0d exp=7", last_ack - first_ack);
    end
    n_cmp++;
    if (rd_cnt !== 8) begin n_fail++; $display("FAIL stream_rd_pulses got=%0d exp=8", rd_cnt); end
    n_cmp++;
    if (overread !== 0) begin n_fail++; $display("FAIL stream_overread got=%0d exp=0", overread); end
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0;
    int ack_cnt = 0;
    int max_occ = 0;
    logic last_rd = 1'b1;
    logic [31:0] exp_v = 32'h41;
    recv_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 0; k < 5; k++) push_word(32'h41 + 32'(k));
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      last_rd = bus.fifo_rd_en;
      if (int'(dut.w_occ) > max_occ) max_occ = int'(dut.w_occ);
    end
    n_cmp++;
    if (rd_cnt !== BUF_DEPTH) begin n_fail++; $display("FAIL bp_prefetch got=%0d exp=%0d", rd_cnt, BUF_DEPTH); end
    n_cmp++;
    if (last_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd_stall got=%b exp=0", last_rd); end
    n_cmp++;
    if (int'(dut.w_occ) !== BUF_DEPTH) begin
      n_fail++; $display("FAIL bp_occ_full got=%0d exp=%0d", dut.w_occ, BUF_DEPTH);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      recv_req = (ack_cnt < 5);
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      if (int'(dut.w_occ) > max_occ) max_occ = int'(dut.w_occ);
      if (bus.recv_ack) begin
        ack_cnt++;
        n_cmp++;
        if (bus.recv_data !== exp_v) begin
          n_fail++; $display("FAIL bp_data got=%h exp=%h", bus.recv_data, exp_v);
        end
        exp_v = exp_v + 1;
      end
    end
    recv_req = 1'b0;
    n_cmp++;
    if (ack_cnt !== 5) begin n_fail++; $display("FAIL bp_acks got=%0d exp=5", ack_cnt); end
    n_cmp++;
    if (rd_cnt !== 5) begin n_fail++; $display("FAIL bp_rd_total got=%0d exp=5", rd_cnt); end
    n_cmp++;
    if (max_occ > BUF_DEPTH) begin n_fail++; $display("FAIL bp_occ_max got=%0d exp<=%0d", max_occ, BUF_DEPTH); end
  endtask

  task automatic test_reset_mid();
    int ack_cnt = 0;
    logic [31:0] got = '0;
    recv_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 0; k < 5; k++) push_word(32'h51 + 32'(k));
    end
    // Buffer full (0x51, 0x52); ack one and launch a read of 0x53.
    @(negedge clk);
    recv_req = 1'b1;
    #1;
    n_cmp++;
    if (bus.recv_ack !== 1'b1 || bus.recv_data !== 32'h51) begin
      n_fail++; $display("FAIL rstmid_pre_ack got=%b/%h exp=1/00000051", bus.recv_ack, bus.recv_data);
    end
    n_cmp++;
    if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_rd got=%b exp=1", bus.fifo_rd_en); end
    // Reset while 0x53 is in flight.
    @(negedge clk);
    rst = 1'b1;
    fifo_rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.recv_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_in_rst got=%b exp=0", bus.recv_ack); end
    @(negedge clk);
    rst = 1'b0;
    fifo_rst = 1'b0;
    #1;
    n_cmp++;
    if (dut.w_occ !== '0) begin n_fail++; $display("FAIL rstmid_occ got=%0d exp=0", dut.w_occ); end
    n_cmp++;
    if (bus.recv_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_after got=%b exp=0", bus.recv_ack); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) push_word(32'h5A);
      #1;
      if (bus.recv_ack) begin
        if (ack_cnt == 0) got = bus.recv_data;
        ack_cnt++;
      end
    end
    recv_req = 1'b0;
    n_cmp++;
    if (ack_cnt !== 1) begin n_fail++; $display("FAIL rstmid_acks got=%0d exp=1", ack_cnt); end
    n_cmp++;
    if (got !== 32'h5A) begin n_fail++; $display("FAIL rstmid_data got=%h exp=0000005a", got); end
  endtask

`ifdef ARGO_CHAN_CLOSE_EN
  task automatic test_close();
    int ok_acks = 0;
    int closed_acks = 0;
    int late_rd = 0;
    recv_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 1; k <= 3; k++) push_word(32'(k));
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chan_closed = 1'b1;
      recv_req = 1'b1;
      if (i == 5) push_word(32'h99);
      #1;
      if (i >= 3 && bus.fifo_rd_en) late_rd++;
      if (bus.recv_ack) begin
        n_cmp++;
        if (ok_acks < 3) begin
          if (bus.recv_ok !== 1'b1 || bus.recv_data !== 32'(ok_acks + 1)) begin
            n_fail++; $display("FAIL close_drain got=%b/%h exp=1/%h", bus.recv_ok, bus.recv_data, 32'(ok_acks + 1));
          end
          ok_acks++;
        end else begin
          if (bus.recv_ok !== 1'b0 || bus.recv_data !== 32'h0) begin
            n_fail++; $display("FAIL close_closed got=%b/%h exp=0/00000000", bus.recv_ok, bus.recv_data);
          end
          closed_acks++;
        end
      end
    end
    n_cmp++;
    if (ok_acks !== 3) begin n_fail++; $display("FAIL close_ok_acks got=%0d exp=3", ok_acks); end
    n_cmp++;
    if (closed_acks !== 8) begin n_fail++; $display("FAIL close_imm_acks got=%0d exp=8", closed_acks); end
    n_cmp++;
    if (late_rd !== 0) begin n_fail++; $display("FAIL close_rd_en got=%0d exp=0", late_rd); end
    @(negedge clk);
    recv_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.recv_ack !== 1'b0) begin n_fail++; $display("FAIL close_no_req_ack got=%b exp=0", bus.recv_ack); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef ARGO_CHAN_CLOSE_EN
    test_close();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
